// File: rtl/core_ctrl_fsm_if.sv
// Memory port handshake between the control sequencer and the shared memory.
//   memReq     : request from the core, held until the ack cycle inclusive
//   memWe      : write strobe, meaningful only while memReq is high
//   memAddrSel : address mux select, 0 = PC, 1 = ALU result
//   memAck     : memory completes the current request this cycle
// The master modport is the sequencer side; the slave modport is the memory side.
interface core_ctrl_fsm_if;
  logic memReq;
  logic memWe;
  logic memAddrSel;
  logic memAck;

  modport master (
    output memReq,
    output memWe,
    output memAddrSel,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddrSel,
    output memAck
  );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and drives
// the datapath strobes from the decoder controls. Instruction fetch and
// load/store share one memory port (mem interface, master side). Retired
// instructions are counted in instret; illegal opcodes and memory requests
// that wait too long park the sequencer in TRAP until reset.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   run                              enable, sampled in IDLE and WB
//   regWrite/memRead/memWrite/
//   branch/jump/jalr/illegal         decoder controls for the current IR
//   brTaken                          branch comparator result
//   mem                              memory handshake (memReq/memWe/memAddrSel/memAck)
//   irWrite, pcWrite, pcSel[1:0]     IR / PC update strobes
//   rfWe, wbSel[1:0]                 register-file write enable and source
//   trap, trapCause                  sticky trap flag, 0 = illegal, 1 = bus timeout
//   state[2:0]                       current state encoding (debug)
//   instret[INSTRET_W-1:0]           retired-instruction count (wraps)
module core_ctrl_fsm #(
  parameter int TIMEOUT   = 16,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 regWrite,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 jalr,
  input  logic                 illegal,
  input  logic                 brTaken,
  core_ctrl_fsm_if.master      mem,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           pcSel,
  output logic                 rfWe,
  output logic [1:0]           wbSel,
  output logic                 trap,
  output logic                 trapCause,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // One extra bit so the counter can step past TIMEOUT-1 on the trap edge.
  localparam int WCNT_W = $clog2(TIMEOUT) + 1;

  state_t                 state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q;
  logic                   trap_q;
  logic                   cause_q, cause_d;
  logic                   trap_set;
  logic                   retire;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   mem_req, mem_we, mem_addr_sel;
  logic                   wait_last;
  logic                   enter_wait;

  // Last cycle a request may stay unacknowledged; an ack here still wins.
  assign wait_last  = (wcnt_q == WCNT_W'(TIMEOUT - 1));
  assign enter_wait = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcSel        = 2'd0;
    rfWe         = 1'b0;
    wbSel        = 2'd0;
    trap_set     = 1'b0;
    cause_d      = cause_q;
    retire       = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem.memAck) begin
          irWrite = 1'b1;
          state_d = DECODE;
        end else if (wait_last) begin
          state_d  = TRAP;
          trap_set = 1'b1;
          cause_d  = 1'b1;
        end
      end
      DECODE: begin
        if (illegal) begin
          state_d  = TRAP;
          trap_set = 1'b1;
          cause_d  = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = (memRead || memWrite) ? MEM : WB;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = memWrite;
        if (mem.memAck) begin
          state_d = WB;
        end else if (wait_last) begin
          state_d  = TRAP;
          trap_set = 1'b1;
          cause_d  = 1'b1;
        end
      end
      WB: begin
        rfWe    = regWrite;
        pcWrite = 1'b1;
        retire  = 1'b1;
        if (memRead)          wbSel = 2'd1;
        else if (jump || jalr) wbSel = 2'd2;
        if (jalr)                          pcSel = 2'd2;
        else if (jump || (branch && brTaken)) pcSel = 2'd1;
        state_d = run ? FETCH : IDLE;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (enter_wait)
        wcnt_q <= '0;
      else if (mem_req && !mem.memAck)
        wcnt_q <= wcnt_q + WCNT_W'(1);
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
      if (retire)
        instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign mem.memReq     = mem_req;
  assign mem.memWe      = mem_we;
  assign mem.memAddrSel = mem_addr_sel;
  assign trap           = trap_q;
  assign trapCause      = cause_q;
  assign state          = state_q;
  assign instret        = instret_q;

endmodule

// File: doc/core_ctrl_fsm.md
# core_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and write-back, driving the datapath strobes from the decoder's control outputs. Shares the single memory port between instruction fetch and load/store over a req/ack handshake. Counts retired instructions and traps on illegal opcodes or a memory timeout.

## Interface
- TIMEOUT, 16: maximum cycles a memory request may wait for memAck (≥2)
- INSTRET_W, 32: width of the retired-instruction counter
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  enable; sampled in IDLE and WB
- regWrite, memRead, memWrite, branch, jump, jalr  in  1 each  decoder controls for the current IR
- illegal  in  1  decoder flag: unsupported opcode
- brTaken  in  1  branch comparator result
- memAck  in  1  memory completes the current request this cycle
- memReq  out  1  memory request
- memWe  out  1  write strobe, valid with memReq
- memAddrSel  out  1  0 = PC, 1 = ALU result
- irWrite  out  1  load IR from memory read data
- pcWrite  out  1  update PC
- pcSel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (jalr)
- rfWe  out  1  register-file write enable
- wbSel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- trap  out  1  sticky trap flag
- trapCause  out  1  0 = illegal instruction, 1 = bus timeout
- state  out  3  current state encoding (debug)
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: memReq=1, memAddrSel=0, memWe=0.
  - On memAck: irWrite=1 that cycle, then go to DECODE.
- DECODE: one cycle.
  - illegal=1: go to TRAP with trapCause=0.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - memRead or memWrite: go to MEM.
  - Otherwise go to WB.
- MEM: memReq=1, memAddrSel=1, memWe=memWrite.
  - On memAck, go to WB.
- WB: one cycle.
  - rfWe=regWrite.
  - wbSel = 1 if memRead; 2 if jump or jalr; else 0.
  - pcWrite=1.
  - pcSel = 2 if jalr; 1 if jump, or if branch and brTaken; else 0.
  - instret increments by 1 and wraps modulo 2^INSTRET_W.
  - Next state: FETCH if run=1, else IDLE.
- TRAP: all strobes 0 and trap=1. Held until reset.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle with memReq=1 and memAck=0.
  - If memAck=0 while the counter equals TIMEOUT-1, go to TRAP with trapCause=1.
  - memAck in that same cycle wins; no trap.
- Strobes are combinational from state and inputs. state, counters, trap and trapCause are registered.
- memAck outside FETCH or MEM is ignored.

## Timing
- Reset values: state=IDLE, every strobe 0, pcSel=0, wbSel=0, trap=0, trapCause=0, instret=0, wait counter 0.
- Async reset mid-handshake drops memReq immediately; no partial retire is counted.
- Latency with memAck in the first request cycle:
  - ALU, branch or jump instruction: 4 cycles, IDLE excluded.
  - Load or store: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- memReq holds high, with address select stable, from the entry cycle until the ack cycle inclusive.
- memReq deasserts in the cycle after ack.
- Back-to-back: WB to FETCH asserts memReq in the next cycle with no bubble.
- instret updates on the clock edge leaving WB.

## Test plan
- Reset, then run=1, ADDI 0x00500093, memAck=1 every request:
  - state sequence 0,1,2,3,5,1.
  - rfWe=1, wbSel=0, pcSel=0 in WB.
  - instret=1.
- SW 0x0021A423, memAck delayed 3 cycles in MEM:
  - memReq=1, memWe=1, memAddrSel=1 for 4 cycles.
  - rfWe=0 in WB.
  - Total 8 cycles FETCH→FETCH.
- BEQ with brTaken=1, then with brTaken=0: pcSel=1 then pcSel=0 in WB; JAL gives pcSel=1, wbSel=2, rfWe=1.
- TIMEOUT=16, memAck never asserted in FETCH:
  - trap=1, trapCause=1 after 16 request cycles.
  - memReq=0 afterwards, held until rst_n.
  - Repeat with memAck on the 16th cycle: no trap.
- illegal=1 in DECODE: TRAP, trapCause=0, instret unchanged. rst_n low mid-MEM: memReq=0 and state=0 immediately.
- INSTRET_W=4, 17 retired instructions: instret=1 after wrap. run=0 during WB: next state IDLE, no memReq.
